uart_rx: RTL and testbench

8N1 UART receiver, the receive-side counterpart of uart_tx on the same serial link. It synchronises the serial line, validates the start bit at mid-bit, and samples 8 data bits LSB-first at bit centres. It checks the stop bit and delivers each byte through a one-entry holding register, with framing and overrun flags. Bit time comes from the same runtime CLKS_PER_BIT input used by the transmitter, so both ends share one baud setting.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both uart_rx and uart_tx.
// Provides the common FSM state encoding, frame geometry and the bit-time clamp.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned MIN_CLKS_PER_BIT = 2;
    localparam int unsigned CPB_W            = 8;
    localparam int unsigned BIT_IDX_W        = $clog2(DATA_BITS);
    localparam int unsigned STATE_W          = 3;

    // Encoding is shared with uart_tx so debug views of both ends line up.
    typedef enum logic [STATE_W-1:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4
    } uart_state_t;

    // Bit times shorter than the minimum cannot place a centre sample.
    function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
        return (cpb < CPB_W'(MIN_CLKS_PER_BIT)) ? CPB_W'(MIN_CLKS_PER_BIT) : cpb;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line.
// Ports: i_Clock, i_Reset (async, active-high, flops reset to idle-high),
//        async_in (raw line), sync_out (line after STAGES cycles).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic async_in,
    output logic sync_out
);

    // Fewer than two flops gives no metastability protection.
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    // Shift chain; reset to 1 so an idle line is not seen as a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-entry holding register, framing and overrun flags.
// Ports: i_Clock, i_Reset (async, active-high), CLKS_PER_BIT (bit time, min 2),
//        i_Rx_Serial (async line, idle high), i_Rd (consume byte), i_Clr_Err,
//        o_Rx_Byte, o_Rx_DV (load pulse), o_Rx_Valid, o_Rx_Active,
//        o_Frame_Err, o_Overrun, s_machine (FSM state for debug).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [CPB_W-1:0]     CLKS_PER_BIT,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rd,
    input  logic                 i_Clr_Err,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_DV,
    output logic                 o_Rx_Valid,
    output logic                 o_Rx_Active,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic [STATE_W-1:0]   s_machine
);

    logic                 rx_s;
    uart_state_t          state_q, state_d;
    logic [CPB_W-1:0]     count_q, count_d;
    logic [CPB_W-1:0]     cpb_q, cpb_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 active_d;
    logic                 load_c;
    logic                 ferr_set_c;
    logic [CPB_W-1:0]     half_c;
    logic [CPB_W-1:0]     last_c;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .async_in(i_Rx_Serial),
        .sync_out(rx_s)
    );

    // Sample points are derived from the bit time latched at start detect.
    assign half_c    = (cpb_q - CPB_W'(1)) >> 1;
    assign last_c    = cpb_q - CPB_W'(1);
    assign s_machine = state_q;

    // State register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= s_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and sample logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cpb_d      = cpb_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        active_d   = o_Rx_Active;
        load_c     = 1'b0;
        ferr_set_c = 1'b0;

        case (state_q)
            s_IDLE: begin
                count_d   = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d  = s_START;
                    active_d = 1'b1;
                    cpb_d    = clamp_cpb(CLKS_PER_BIT);
                end
            end

            // A start bit that is no longer low at mid-bit is treated as noise.
            s_START: begin
                if (count_q == half_c) begin
                    count_d = '0;
                    if (!rx_s) begin
                        state_d = s_DATA;
                    end else begin
                        state_d  = s_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + CPB_W'(1);
                end
            end

            s_DATA: begin
                if (count_q == last_c) begin
                    count_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = s_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    count_d = count_q + CPB_W'(1);
                end
            end

            s_STOP: begin
                if (count_q == last_c) begin
                    count_d = '0;
                    if (rx_s) begin
                        load_c = 1'b1;
                    end else begin
                        ferr_set_c = 1'b1;
                    end
                    state_d = s_CLEANUP;
                end else begin
                    count_d = count_q + CPB_W'(1);
                end
            end

            // Wait for the line to return high so a break is one frame only.
            s_CLEANUP: begin
                if (rx_s) begin
                    state_d  = s_IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d  = s_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs; a load beats a same-cycle read.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count_q     <= '0;
            cpb_q       <= CPB_W'(MIN_CLKS_PER_BIT);
            bit_idx_q   <= '0;
            shift_q     <= '0;
            o_Rx_Byte   <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Valid  <= 1'b0;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            count_q     <= count_d;
            cpb_q       <= cpb_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            o_Rx_Active <= active_d;
            o_Rx_DV     <= load_c;

            if (load_c) begin
                o_Rx_Byte <= shift_q;
            end

            if (load_c) begin
                o_Rx_Valid <= 1'b1;
            end else if (i_Rd) begin
                o_Rx_Valid <= 1'b0;
            end

            if (load_c && o_Rx_Valid && !i_Rd) begin
                o_Overrun <= 1'b1;
            end else if (i_Clr_Err) begin
                o_Overrun <= 1'b0;
            end

            if (ferr_set_c) begin
                o_Frame_Err <= 1'b1;
            end else if (i_Clr_Err) begin
                o_Frame_Err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of clean frames plus directed corner sequences.
module tb_uart_rx;

    logic       i_Clock;
    logic       i_Reset;
    logic [7:0] CLKS_PER_BIT;
    logic       i_Rx_Serial;
    logic       i_Rd;
    logic       i_Clr_Err;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_DV;
    logic       o_Rx_Valid;
    logic       o_Rx_Active;
    logic       o_Frame_Err;
    logic       o_Overrun;
    logic [2:0] s_machine;

    int n_cmp = 0;
    int n_bad = 0;
    int dv_count = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .i_Rx_Serial (i_Rx_Serial),
        .i_Rd        (i_Rd),
        .i_Clr_Err   (i_Clr_Err),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Valid  (o_Rx_Valid),
        .o_Rx_Active (o_Rx_Active),
        .o_Frame_Err (o_Frame_Err),
        .o_Overrun   (o_Overrun),
        .s_machine   (s_machine)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Count cycles with o_Rx_DV high; one frame must add exactly one.
    always @(negedge i_Clock) begin
        if (o_Rx_DV) dv_count <= dv_count + 1;
    end

    typedef struct {
        logic [7:0] cpb_in;
        int         bit_len;
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame starting at a negedge; the line is left at the stop level.
    task automatic drive_frame(input logic [7:0] data, input logic stop, input int bit_len);
        i_Rx_Serial = 1'b0;
        repeat (bit_len) @(negedge i_Clock);
        for (int i = 0; i < 8; i++) begin
            i_Rx_Serial = data[i];
            repeat (bit_len) @(negedge i_Clock);
        end
        i_Rx_Serial = stop;
        repeat (bit_len) @(negedge i_Clock);
    endtask

    task automatic pulse_rd();
        i_Rd = 1'b1;
        @(negedge i_Clock);
        i_Rd = 1'b0;
    endtask

    task automatic pulse_clr();
        i_Clr_Err = 1'b1;
        @(negedge i_Clock);
        i_Clr_Err = 1'b0;
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] data, input int bit_len);
        int dv0;
        dv0 = dv_count;
        drive_frame(data, 1'b1, bit_len);
        repeat (4) @(negedge i_Clock);
        check({tag, " dv_pulses"}, 32'(dv_count - dv0), 32'd1);
        check({tag, " byte"}, 32'(o_Rx_Byte), 32'(data));
        check({tag, " valid"}, 32'(o_Rx_Valid), 32'd1);
    endtask

    initial begin
        int dv0;
        logic [7:0] b;

        vecs[0] = '{8'd10, 10, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'd87, 87, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'd87, 87, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'd87, 87, 8'h55, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'd1,  2,  8'h96, 8'h96, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'd1,  2,  8'h6B, 8'h6B, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'd0,  2,  8'hC8, 8'hC8, 1'b1, 1'b0, 1'b0};

        i_Reset      = 1'b1;
        CLKS_PER_BIT = 8'd10;
        i_Rx_Serial  = 1'b1;
        i_Rd         = 1'b0;
        i_Clr_Err    = 1'b0;

        // Reset state
        #1;
        check("rst byte", 32'(o_Rx_Byte), 32'd0);
        check("rst dv", 32'(o_Rx_DV), 32'd0);
        check("rst valid", 32'(o_Rx_Valid), 32'd0);
        check("rst active", 32'(o_Rx_Active), 32'd0);
        check("rst ferr", 32'(o_Frame_Err), 32'd0);
        check("rst ovr", 32'(o_Overrun), 32'd0);
        check("rst state", 32'(s_machine), 32'd0);
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (3) @(negedge i_Clock);
        check("post-rst state", 32'(s_machine), 32'd0);

        // Table of clean frames, each consumed with i_Rd afterwards
        for (int v = 0; v < 7; v++) begin
            dv0 = dv_count;
            CLKS_PER_BIT = vecs[v].cpb_in;
            drive_frame(vecs[v].data, 1'b1, vecs[v].bit_len);
            repeat (4) @(negedge i_Clock);
            check($sformatf("vec%0d dv_pulses", v), 32'(dv_count - dv0), 32'd1);
            check($sformatf("vec%0d byte", v), 32'(o_Rx_Byte), 32'(vecs[v].exp_byte));
            check($sformatf("vec%0d valid", v), 32'(o_Rx_Valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d ferr", v), 32'(o_Frame_Err), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d ovr", v), 32'(o_Overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d active", v), 32'(o_Rx_Active), 32'd0);
            check($sformatf("vec%0d state", v), 32'(s_machine), 32'd0);
            pulse_rd();
            @(negedge i_Clock);
            check($sformatf("vec%0d rd clears", v), 32'(o_Rx_Valid), 32'd0);
        end

        // Start glitch: 3 low cycles is shorter than the half-bit point
        CLKS_PER_BIT = 8'd10;
        dv0 = dv_count;
        i_Rx_Serial = 1'b0;
        repeat (3) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (3) @(negedge i_Clock);
        check("glitch in start", 32'(s_machine), 32'd1);
        check("glitch active", 32'(o_Rx_Active), 32'd1);
        repeat (4) @(negedge i_Clock);
        check("glitch back idle", 32'(s_machine), 32'd0);
        check("glitch active off", 32'(o_Rx_Active), 32'd0);
        check("glitch no dv", 32'(dv_count - dv0), 32'd0);
        check("glitch no ferr", 32'(o_Frame_Err), 32'd0);
        frame_and_check("after glitch", 8'h3C, 10);
        pulse_rd();

        // Framing error with the line held low past the stop bit
        dv0 = dv_count;
        drive_frame(8'h3C, 1'b0, 10);
        repeat (20) @(negedge i_Clock);
        check("ferr set", 32'(o_Frame_Err), 32'd1);
        check("ferr state cleanup", 32'(s_machine), 32'd4);
        check("ferr valid stays 0", 32'(o_Rx_Valid), 32'd0);
        check("ferr no dv", 32'(dv_count - dv0), 32'd0);
        check("ferr active", 32'(o_Rx_Active), 32'd1);
        i_Rx_Serial = 1'b1;
        repeat (4) @(negedge i_Clock);
        check("ferr idle after high", 32'(s_machine), 32'd0);
        check("ferr sticky", 32'(o_Frame_Err), 32'd1);
        pulse_clr();
        check("ferr cleared", 32'(o_Frame_Err), 32'd0);

        // Overrun: two frames without reading
        frame_and_check("ovr first", 8'h11, 10);
        check("ovr none yet", 32'(o_Overrun), 32'd0);
        frame_and_check("ovr second", 8'h22, 10);
        check("ovr set", 32'(o_Overrun), 32'd1);
        pulse_clr();
        check("ovr cleared", 32'(o_Overrun), 32'd0);
        check("ovr valid kept", 32'(o_Rx_Valid), 32'd1);

        // Read in the exact load cycle: stop sample lands 97 negedges after start
        dv0 = dv_count;
        fork
            drive_frame(8'h33, 1'b1, 10);
            begin
                repeat (97) @(negedge i_Clock);
                pulse_rd();
            end
        join
        repeat (4) @(negedge i_Clock);
        check("rd+load dv", 32'(dv_count - dv0), 32'd1);
        check("rd+load no ovr", 32'(o_Overrun), 32'd0);
        check("rd+load valid", 32'(o_Rx_Valid), 32'd1);
        check("rd+load byte", 32'(o_Rx_Byte), 32'h33);

        // Reset in the middle of the data bits of 0x5A
        b = 8'h5A;
        i_Rx_Serial = 1'b0;
        repeat (10) @(negedge i_Clock);
        for (int i = 0; i < 3; i++) begin
            i_Rx_Serial = b[i];
            repeat (10) @(negedge i_Clock);
        end
        check("pre-rst in data", 32'(s_machine), 32'd2);
        #2 i_Reset = 1'b1;
        #1;
        check("midrst byte", 32'(o_Rx_Byte), 32'd0);
        check("midrst valid", 32'(o_Rx_Valid), 32'd0);
        check("midrst active", 32'(o_Rx_Active), 32'd0);
        check("midrst state", 32'(s_machine), 32'd0);
        check("midrst dv", 32'(o_Rx_DV), 32'd0);
        i_Rx_Serial = 1'b1;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (4) @(negedge i_Clock);
        check("after rst idle", 32'(s_machine), 32'd0);
        frame_and_check("after rst", 8'hC3, 10);
        check("after rst ferr", 32'(o_Frame_Err), 32'd0);
        check("after rst ovr", 32'(o_Overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
